gf2_four_way_mul_seq: RTL and testbench

Parametrised, digit-serial 4-way split multiplier over GF(2)[x] (carry-less) with a start/done handshake. It is the successor to the fixed 224x224 free-running four-way multiplier. Operands split into four N = WIDTH/4 limbs. The 16 limb products are accumulated into 7 coefficient registers, DIGIT bits of each a-limb per cycle, then recombined into a registered 2*WIDTH-bit product. It sits in the large-integer/binary-field multiplier library as a drop-in core for ECC/PQC datapaths that need a bounded, handshaked latency.

---
 rtl/gf2_mul_pkg.sv | 46 ++++
 rtl/gf2_four_way_mul_seq_if.sv | 23 ++
 rtl/gf2_coeff_acc.sv | 58 +++++
 rtl/gf2_four_way_mul_seq.sv | 127 ++++++++++++
 tb/tb_gf2_four_way_mul_seq.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf2_mul_pkg.sv
// Shared types and elaboration helpers for the digit-serial four-way GF(2)[x] multiplier.
package gf2_mul_pkg;

  // Controller states: operand capture, digit-serial accumulation, recombination, result strobe.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMB = 2'd2,
    DONE = 2'd3
  } state_e;

  // Four limbs per operand give seven partial-product coefficients (degrees 0..6 in x^N).
  localparam int NUM_LIMBS = 4;
  localparam int NUM_COEFF = 2 * NUM_LIMBS - 1;

  // Limb width N.
  function automatic int limb_w(input int width);
    return width / NUM_LIMBS;
  endfunction

  // Number of MUL cycles: one digit of every a-limb per cycle.
  function automatic int digit_steps(input int width, input int digit);
    return limb_w(width) / digit;
  endfunction

  // Digit counter width; at least one bit even when a single step suffices.
  function automatic int cnt_w(input int width, input int digit);
    return (digit_steps(width, digit) > 1) ? $clog2(digit_steps(width, digit)) : 1;
  endfunction

  // Start-accept edge to done-visible edge.
  function automatic int latency(input int width, input int digit);
    return digit_steps(width, digit) + 2;
  endfunction

  // Lowest a-limb index contributing to coefficient k (pairs i+j=k, 0<=i,j<=3).
  function automatic int pair_lo(input int k);
    return (k > NUM_LIMBS - 1) ? k - (NUM_LIMBS - 1) : 0;
  endfunction

  // Number of (i,j) limb pairs with i+j=k.
  function automatic int pair_cnt(input int k);
    return (k > NUM_LIMBS - 1) ? (NUM_COEFF - k) : (k + 1);
  endfunction

endpackage

// File: rtl/gf2_four_way_mul_seq_if.sv
// Start/done handshake bundle for the four-way GF(2)[x] multiplier.
interface gf2_four_way_mul_seq_if #(
  parameter int WIDTH = 224
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   c;

  // Requester side: issues operands and start, observes status and product.
  modport master (
    output start, a, b,
    input  busy, done, c
  );

  // Multiplier side.
  modport slave (
    input  start, a, b,
    output busy, done, c
  );
endinterface

// File: rtl/gf2_coeff_acc.sv
// One coefficient accumulator: XORs DIGIT shifted copies of each b-limb per cycle,
// gated by the matching a-limb digit bits, into a 2N-1 bit carry-less partial sum.
module gf2_coeff_acc #(
  parameter int N      = 56,
  parameter int DIGIT  = 1,
  parameter int NPAIRS = 1,
  parameter int CNT_W  = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic [CNT_W-1:0]               cnt_i,
  input  logic [NPAIRS-1:0][DIGIT-1:0]   a_sl_i,
  input  logic [NPAIRS-1:0][N-1:0]       b_i,
  output logic [2*N-2:0]                 acc_o
);

  localparam int AW = 2 * N - 1;

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [AW-1:0] upd;

  // Partial product of this digit: bit t of the digit weights b by x^(cnt*DIGIT+t).
  always_comb begin
    upd = '0;
    for (int p = 0; p < NPAIRS; p++) begin
      for (int t = 0; t < DIGIT; t++) begin
        if (a_sl_i[p][t]) begin
          upd = upd ^ (AW'(b_i[p]) << (int'(cnt_i) * DIGIT + t));
        end
      end
    end
  end

  // Clear on a new operation has priority over accumulation.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ upd;
    end
  end

  // Accumulator register, cleared by reset so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/gf2_four_way_mul_seq.sv
// Digit-serial four-way split carry-less multiplier: seven coefficient accumulators
// fed by limb pairs, recombined into a registered 2*WIDTH product with a done strobe.
module gf2_four_way_mul_seq
  import gf2_mul_pkg::*;
#(
  parameter int WIDTH = 224,
  parameter int DIGIT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gf2_four_way_mul_seq_if.slave   mul_if
);

  localparam int N     = limb_w(WIDTH);
  localparam int STEPS = digit_steps(WIDTH, DIGIT);
  localparam int CW    = cnt_w(WIDTH, DIGIT);
  localparam int AW    = 2 * N - 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  state_e                          state_q;
  logic [NUM_LIMBS-1:0][N-1:0]     a_q;
  logic [NUM_LIMBS-1:0][N-1:0]     b_q;
  logic [CW-1:0]                   cnt_q;
  logic                            busy_q;
  logic                            done_q;
  logic [PW-1:0]                   c_q;
  logic [PW-1:0]                   c_d;
  logic [NUM_COEFF-1:0][AW-1:0]    acc;
  logic                            accept;
  logic                            acc_en;

  // A request is taken only when no operation is in flight (IDLE or the DONE strobe cycle).
  assign accept = mul_if.start && ((state_q == IDLE) || (state_q == DONE));
  assign acc_en = (state_q == MUL);

  // a-limbs are shifted right each MUL cycle, so the current digit always sits in the low bits.
  for (genvar gi = 0; gi < NUM_COEFF; gi++) begin : g_coeff
    localparam int LO = pair_lo(gi);
    localparam int NP = pair_cnt(gi);

    logic [NP-1:0][DIGIT-1:0] a_sl;
    logic [NP-1:0][N-1:0]     b_sl;

    for (genvar gp = 0; gp < NP; gp++) begin : g_pair
      assign a_sl[gp] = a_q[LO + gp][DIGIT-1:0];
      assign b_sl[gp] = b_q[gi - LO - gp];
    end

    gf2_coeff_acc #(
      .N      (N),
      .DIGIT  (DIGIT),
      .NPAIRS (NP),
      .CNT_W  (CW)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (accept),
      .en_i   (acc_en),
      .cnt_i  (cnt_q),
      .a_sl_i (a_sl),
      .b_i    (b_sl),
      .acc_o  (acc[gi])
    );
  end

  // Recombination: coefficient k carries weight x^(k*N); overlaps cancel by XOR.
  always_comb begin
    c_d = '0;
    for (int k = 0; k < NUM_COEFF; k++) begin
      c_d = c_d ^ (PW'(acc[k]) << (k * N));
    end
  end

  // Controller with registered busy/done/product; reset aborts any run silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            a_q     <= mul_if.a;
            b_q     <= mul_if.b;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        MUL: begin
          for (int l = 0; l < NUM_LIMBS; l++) begin
            a_q[l] <= a_q[l] >> DIGIT;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= COMB;
          end
        end
        COMB: begin
          c_q     <= c_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mul_if.busy = busy_q;
  assign mul_if.done = done_q;
  assign mul_if.c    = c_q;

endmodule

// File: tb/tb_gf2_four_way_mul_seq.sv
// Bench for gf2_four_way_mul_seq: three instances (224/1, 224/8, 64/4) checked every
// cycle against a timing-plus-bitwise-clmul reference, plus literal directed results.
module tb_gf2_four_way_mul_seq;

  localparam int LAT [3] = '{58, 9, 6};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gf2_four_way_mul_seq_if #(.WIDTH(224)) if0 ();
  gf2_four_way_mul_seq_if #(.WIDTH(224)) if1 ();
  gf2_four_way_mul_seq_if #(.WIDTH(64))  if2 ();

  gf2_four_way_mul_seq #(.WIDTH(224), .DIGIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .mul_if(if0));
  gf2_four_way_mul_seq #(.WIDTH(224), .DIGIT(8)) dut1 (.clk(clk), .rst_n(rst_n), .mul_if(if1));
  gf2_four_way_mul_seq #(.WIDTH(64),  .DIGIT(4)) dut2 (.clk(clk), .rst_n(rst_n), .mul_if(if2));

  logic         drv_start [3];
  logic [223:0] drv_a [3];
  logic [223:0] drv_b [3];
  logic [223:0] m_a [3];
  logic [223:0] m_b [3];
  logic         o_busy [3];
  logic         o_done [3];
  logic [447:0] o_c [3];

  assign if0.start = drv_start[0];
  assign if0.a     = drv_a[0];
  assign if0.b     = drv_b[0];
  assign if1.start = drv_start[1];
  assign if1.a     = drv_a[1];
  assign if1.b     = drv_b[1];
  assign if2.start = drv_start[2];
  assign if2.a     = drv_a[2][63:0];
  assign if2.b     = drv_b[2][63:0];

  assign m_a[0] = drv_a[0];
  assign m_b[0] = drv_b[0];
  assign m_a[1] = drv_a[1];
  assign m_b[1] = drv_b[1];
  assign m_a[2] = {160'b0, drv_a[2][63:0]};
  assign m_b[2] = {160'b0, drv_b[2][63:0]};

  assign o_busy[0] = if0.busy;
  assign o_done[0] = if0.done;
  assign o_c[0]    = if0.c;
  assign o_busy[1] = if1.busy;
  assign o_done[1] = if1.done;
  assign o_c[1]    = if1.c;
  assign o_busy[2] = if2.busy;
  assign o_done[2] = if2.done;
  assign o_c[2]    = {320'b0, if2.c};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Bitwise carry-less product.
  function automatic logic [447:0] clmul(input logic [223:0] x, input logic [223:0] y);
    logic [447:0] r;
    r = '0;
    for (int i = 0; i < 224; i++) begin
      if (x[i]) r = r ^ ({224'b0, y} << i);
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  int           cyc = 0;
  bit           inflight [3];
  int           t_acc [3];
  logic [447:0] pend [3];
  logic [447:0] c_exp [3];
  logic         done_exp [3];
  logic         busy_exp [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit accepts(input int u);
    return (drv_start[u] === 1'b1) && !inflight[u];
  endfunction

  // Accepted start at edge T: busy after edges T..T+L-2, done and new c after edge T+L-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 3; u++) begin
        inflight[u] <= 1'b0;
        t_acc[u]    <= 0;
        pend[u]     <= '0;
        c_exp[u]    <= '0;
        done_exp[u] <= 1'b0;
        busy_exp[u] <= 1'b0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        done_exp[u] <= inflight[u] && (cyc == t_acc[u] + LAT[u] - 1);
        if (inflight[u] && (cyc == t_acc[u] + LAT[u] - 1)) c_exp[u] <= pend[u];
        busy_exp[u] <= accepts(u) || (inflight[u] && (cyc <= t_acc[u] + LAT[u] - 2));
        if (accepts(u)) begin
          inflight[u] <= 1'b1;
          t_acc[u]    <= cyc;
          pend[u]     <= clmul(m_a[u], m_b[u]);
        end else if (inflight[u] && (cyc >= t_acc[u] + LAT[u] - 1)) begin
          inflight[u] <= 1'b0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [447:0] got, input logic [447:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [223:0] rnd_operand();
    logic [223:0] r;
    r = '0;
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      2: r[$urandom_range(0, 223)] = 1'b1;
      default: for (int w = 0; w < 7; w++) r[32*w +: 32] = $urandom;
    endcase
    return r;
  endfunction

  // Issue one op on unit 0 (called at negedge+1); optional start pulse mid-run.
  task automatic run_op(input logic [223:0] a, input logic [223:0] b, input int pulse_at,
                        output int lat_o, output int busy_o, output logic [447:0] c_o);
    lat_o = -1;
    busy_o = 0;
    c_o = '0;
    drv_a[0] = a;
    drv_b[0] = b;
    drv_start[0] = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (o_busy[0]) busy_o++;
      if (o_done[0]) begin
        lat_o = i;
        c_o = o_c[0];
        break;
      end
      #1;
      if (i == 1 || i == pulse_at + 1) drv_start[0] = 1'b0;
      if (i == pulse_at) begin
        drv_start[0] = 1'b1;
        drv_a[0] = ~a;
        drv_b[0] = b ^ 224'hff;
      end
    end
    drv_start[0] = 1'b0;
    #1;
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_done[0]) cnt++;
    end
    #1;
  endtask

  task automatic rnd_run(input int u, output int ops);
    ops = 0;
    for (int n = 0; n < 40000 && ops < 1000; n++) begin
      @(negedge clk);
      if (o_done[u]) ops++;
      #1;
      drv_start[u] = ($urandom_range(0, 2) != 0);
      drv_a[u] = rnd_operand();
      drv_b[u] = rnd_operand();
    end
    drv_start[u] = 1'b0;
  endtask

  // ---------------- stimulus + compare process ----------------
  initial begin
    int lat, bcnt, nd, ops1, ops2;
    logic [447:0] c_got, e;
    logic [223:0] ones, ta, tb_;
    logic [223:0] ba [3];
    logic [223:0] bb [3];

    for (int u = 0; u < 3; u++) begin
      drv_start[u] = 1'b0;
      drv_a[u] = '0;
      drv_b[u] = '0;
    end

    // Every-cycle comparison of all instances against the reference model.
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d busy", u), {447'b0, o_busy[u]}, {447'b0, busy_exp[u]});
            chk($sformatf("u%0d done", u), {447'b0, o_done[u]}, {447'b0, done_exp[u]});
            chk($sformatf("u%0d c", u), o_c[u], c_exp[u]);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset busy", {447'b0, o_busy[0]}, 448'd0);
    chk("reset done", {447'b0, o_done[0]}, 448'd0);
    chk("reset c", o_c[0], 448'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // 3 x 3 carry-less is 5, with 58-cycle latency and 57 busy cycles.
    run_op(224'd3, 224'd3, -5, lat, bcnt, c_got);
    $display("op 3*3: latency %0d busy %0d c=%0h", lat, bcnt, c_got);
    chk("3x3 c", c_got, 448'd5);
    chk("3x3 latency", 448'(lat), 448'd58);
    chk("3x3 busy cycles", 448'(bcnt), 448'd57);

    // Top bits: x^223 * x^223 = x^446.
    ta = '0;
    ta[223] = 1'b1;
    e = '0;
    e[446] = 1'b1;
    run_op(ta, ta, -5, lat, bcnt, c_got);
    $display("op msb*msb: latency %0d c=%0h", lat, c_got);
    chk("msb sq c", c_got, e);

    // all-ones * 1 = a, upper half zero.
    ones = '1;
    run_op(ones, 224'd1, -5, lat, bcnt, c_got);
    $display("op ones*1: latency %0d c=%0h", lat, c_got);
    chk("ones x 1 c", c_got, {224'b0, ones});

    // Start pulse at +10 with other operands is ignored: 5*7 = 27, exactly one done.
    run_op(224'd5, 224'd7, 10, lat, bcnt, c_got);
    $display("op 5*7 with ignored restart: latency %0d c=%0h", lat, c_got);
    chk("ignore c", c_got, 448'd27);
    chk("ignore latency", 448'(lat), 448'd58);
    count_dones(70, nd);
    chk("ignore extra dones", 448'(nd), 448'd0);

    // Asynchronous reset mid-run clears outputs at once and suppresses done.
    drv_a[0] = 224'h1234_5678_9abc;
    drv_b[0] = 224'hfedc_ba98;
    drv_start[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      if (i == 1) drv_start[0] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    $display("async reset mid-run: busy %0b done %0b c=%0h", o_busy[0], o_done[0], o_c[0]);
    chk("async rst busy", {447'b0, o_busy[0]}, 448'd0);
    chk("async rst done", {447'b0, o_done[0]}, 448'd0);
    chk("async rst c", o_c[0], 448'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    count_dones(70, nd);
    chk("aborted run dones", 448'(nd), 448'd0);
    ta = rnd_operand();
    tb_ = rnd_operand();
    run_op(ta, tb_, -5, lat, bcnt, c_got);
    $display("op after reset: latency %0d c=%0h", lat, c_got);
    chk("post-reset c", c_got, clmul(ta, tb_));
    chk("post-reset latency", 448'(lat), 448'd58);

    // Back-to-back with start held high: dones at +58, +116, +174.
    for (int n = 0; n < 3; n++) begin
      ba[n] = rnd_operand();
      bb[n] = rnd_operand();
    end
    drv_a[0] = ba[0];
    drv_b[0] = bb[0];
    drv_start[0] = 1'b1;
    nd = 0;
    for (int i = 1; i <= 400 && nd < 3; i++) begin
      @(negedge clk);
      if (o_done[0]) begin
        $display("b2b op %0d: done at +%0d c=%0h", nd, i, o_c[0]);
        chk($sformatf("b2b %0d time", nd), 448'(i), 448'(58 * (nd + 1)));
        chk($sformatf("b2b %0d c", nd), o_c[0], clmul(ba[nd], bb[nd]));
        nd++;
        #1;
        if (nd < 3) begin
          drv_a[0] = ba[nd];
          drv_b[0] = bb[nd];
        end else begin
          drv_start[0] = 1'b0;
        end
      end
    end
    drv_start[0] = 1'b0;
    chk("b2b done count", 448'(nd), 448'd3);

    // Random operands on the 224/8 and 64/4 instances, checked by the compare process.
    fork
      rnd_run(1, ops1);
      rnd_run(2, ops2);
    join
    repeat (15) @(negedge clk);
    $display("random: %0d ops on 224/8, %0d ops on 64/4", ops1, ops2);
    chk("rnd 224/8 ops", 448'(ops1), 448'd1000);
    chk("rnd 64/4 ops", 448'(ops2), 448'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
